mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one signed fractional multiplier (`mult` datapath, SIZE-bit Q1.(SIZE-1)) between NUM_REQ requesters.
- Requesters are served in round-robin order through a valid/ready handshake.
- Two-stage register pipeline: operand stage, then result stage. Full-throughput, with backpressure from a single consumer.
- Sits between the CNN/filter compute units and the shared arithmetic resource; each result is tagged with the ID of the requester that issued it.

Parameters:
- SIZE, 16, operand/result width in bits; signed Q1.(SIZE-1).
- NUM_REQ, 4, number of requesters; must be >= 2.
- ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*SIZE  packed operand A; requester i occupies bits [i*SIZE +: SIZE].
- req_b  input  NUM_REQ*SIZE  packed operand B, same packing as req_a.
- req_ready  output  NUM_REQ  one-hot (or zero) grant/accept.
- out_valid  output  1  result valid.
- out_data  output  SIZE  fractional product.
- out_id  output  ID_W  index of the requester that issued the result.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  s1_valid | out_valid.

Behaviour:
- Reset, synchronous on rst=1 at a clock edge:
  - s1_valid=0, out_valid=0, out_data=0, out_id=0, rr_ptr=0.
  - req_ready is forced to 0 while rst=1.
  - Reset mid-operation discards in-flight stage-1 and stage-2 contents without emitting them.
- Pipeline enables:
  - adv2 = !out_valid | out_ready
  - adv1 = !s1_valid | adv2
- Arbitration, combinational:
  - Candidate g is the first i with req_valid[i]=1, scanning i = rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - req_ready[g] = adv1 & |req_valid & !rst. All other req_ready bits are 0.
  - req_ready may depend combinationally on out_ready; this is accepted.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] at a clock edge.
  - On transfer: stage 1 latches req_a[g], req_b[g], id=g, s1_valid=1; rr_ptr <= (g+1) mod NUM_REQ.
  - Without a transfer, rr_ptr holds. A requester that deasserts req_valid before being granted loses no fairness.
- Stage 1 to stage 2: when adv2, out_valid <= s1_valid. If s1_valid, out_data <= the product and out_id <= the stage-1 id.
- Stage 1 refill: when adv1 and there is no transfer, s1_valid <= 0.
- Arithmetic:
  - Full product p = signed(a)*signed(b), width 2*SIZE.
  - out_data = p[2*SIZE-2 : SIZE-1]. This truncates toward -inf with no rounding.
  - No saturation: (-1.0)*(-1.0) wraps to -1.0.
- Latency and throughput:
  - A transfer at edge E gives out_valid=1 after edge E+1 (2 edges).
  - With out_ready held high, throughput is one result per cycle.
- Stall (out_valid=1, out_ready=0):
  - out_data and out_id are held stable.
  - s1 holds if full; if empty, s1 accepts exactly one more request.
  - At most 2 requests are in flight. Nothing is lost or duplicated.
- Simultaneous pop and accept (out_ready=1 with both stages full): stage 2 takes stage 1, and stage 1 takes the new request in the same edge.
- Ordering: results emerge in grant order.

Test Plan:
1. Reset then single op, SIZE=16: requester 2 sends a=0x4000, b=0x4000 → req_ready=4'b0100 for one cycle; out_valid 2 edges later with out_data=0x2000, out_id=2.
2. Arithmetic corners:
   - 0xC000*0x4000 → 0xE000.
   - 0xFFFF*0x0001 → 0xFFFF (floor).
   - 0x8000*0x8000 → 0x8000 (wrap).
   - 0x7FFF*0x7FFF → 0x7FFE.
3. Round-robin: all four req_valid held high, out_ready=1 for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles; out_id follows the same sequence at 1 result/cycle.
4. Fairness skip: after requester 1 is granted, only requesters 0 and 3 are valid → next grant is 3, then 0. A requester dropping valid without a grant leaves rr_ptr unchanged.
5. Backpressure: stream active, out_ready=0 for 5 cycles → exactly 2 accepts in flight, then req_ready=0; out_data/out_id stable. On releasing out_ready, the remaining results emerge in order with no loss or duplicate.
6. Reset mid-stream: rst=1 for one edge while both stages are full → out_valid=0, busy=0, req_ready=0 during rst; the next grant starts at requester 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin shares one signed Q1.(SIZE-1) fractional multiplier among NUM_REQ requesters; results carry the requester ID.
// Latency: a request accepted at edge E appears on out_valid after edge E+1. Throughput is one result per cycle.
// Backpressure: out_ready low freezes the result stage. The operand stage accepts one more request if empty, then req_ready drops.
module mult_share_arbiter #(
   parameter int SIZE    = 16,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*SIZE-1:0] req_a,
   input  logic [NUM_REQ*SIZE-1:0] req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    out_valid,
   output logic [SIZE-1:0]         out_data,
   output logic [ID_W-1:0]         out_id,
   input  logic                    out_ready,
   output logic                    busy
);

   // operand stage
   logic [SIZE-1:0]         r_s1_a;
   logic [SIZE-1:0]         r_s1_b;
   logic [ID_W-1:0]         r_s1_id;
   logic                    r_s1_vld;
   // result stage
   logic                    r_out_vld;
   logic [SIZE-1:0]         r_out_data;
   logic [ID_W-1:0]         r_out_id;
   // round-robin start point: requester after the last one granted
   logic [ID_W-1:0]         r_rr_ptr;

   logic                    w_adv2;
   logic                    w_adv1;
   logic                    w_any;
   logic [ID_W-1:0]         w_gnt_id;
   logic [ID_W-1:0]         w_scan_id;
   logic [ID_W-1:0]         w_rr_next;
   logic [NUM_REQ-1:0]      w_req_ready;
   logic                    w_xfer;
   logic [SIZE-1:0]         w_a_arr [NUM_REQ];
   logic [SIZE-1:0]         w_b_arr [NUM_REQ];
   logic signed [2*SIZE-1:0] w_prod;
   logic                    w_prod_unused;

   // Unpack the per-requester operand lanes so the grant can index them directly.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_a_arr[gi] = req_a[gi*SIZE +: SIZE];
      assign w_b_arr[gi] = req_b[gi*SIZE +: SIZE];
   end

   // A stage may load when its current content leaves or it is empty.
   assign w_adv2 = !r_out_vld | out_ready;
   assign w_adv1 = !r_s1_vld | w_adv2;

   // Pick the first valid requester scanning upward from r_rr_ptr, wrapping around.
   always_comb begin
      w_any     = 1'b0;
      w_gnt_id  = '0;
      w_scan_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan_id = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         if (!w_any && req_valid[w_scan_id]) begin
            w_any    = 1'b1;
            w_gnt_id = w_scan_id;
         end
      end
   end

   // Grant is one-hot when the operand stage can load. It is held off entirely during reset.
   always_comb begin
      w_req_ready = '0;
      if (w_any && w_adv1 && !rst) begin
         w_req_ready[w_gnt_id] = 1'b1;
      end
   end

   assign w_xfer    = |(req_valid & w_req_ready);
   assign w_rr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

   // Full signed product. Keep the Q1 window p[2*SIZE-2:SIZE-1], truncating toward -inf without saturation.
   assign w_prod        = $signed(r_s1_a) * $signed(r_s1_b);
   assign w_prod_unused = ^{w_prod[2*SIZE-1], w_prod[SIZE-2:0]};

   // Pipeline and arbitration state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld   <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_id    <= '0;
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
         r_out_id   <= '0;
         r_rr_ptr   <= '0;
      end else begin
         if (w_adv2) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_out_data <= w_prod[2*SIZE-2:SIZE-1];
               r_out_id   <= r_s1_id;
            end
         end
         if (w_adv1) begin
            r_s1_vld <= w_xfer;
            if (w_xfer) begin
               r_s1_a  <= w_a_arr[w_gnt_id];
               r_s1_b  <= w_b_arr[w_gnt_id];
               r_s1_id <= w_gnt_id;
            end
         end
         if (w_xfer) begin
            r_rr_ptr <= w_rr_next;
         end
      end
   end

   assign req_ready = w_req_ready;
   assign out_valid = r_out_vld;
   assign out_data  = r_out_data;
   assign out_id    = r_out_id;
   assign busy      = r_s1_vld | r_out_vld;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed testbench for mult_share_arbiter, with a scoreboard queue and an independent output monitor.
// Latency: expected results are queued at grant time and popped on each output handshake.
// Backpressure: stall windows drive out_ready low and check that the result is held stable.
module tb_mult_share_arbiter;

   localparam int SIZE    = 16;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*SIZE-1:0] req_a;
   logic [NUM_REQ*SIZE-1:0] req_b;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    out_valid;
   logic [SIZE-1:0]         out_data;
   logic [ID_W-1:0]         out_id;
   logic                    out_ready;
   logic                    busy;

   int vectors     = 0;
   int miscompares = 0;
   logic [ID_W+SIZE-1:0] sb [$];

   mult_share_arbiter #(.SIZE(SIZE), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Watchdog: the run must end on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // Monitor: every output handshake pops one expected {id,data} in order.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL out_unexpected: got id=%0d data=%h, required no output", out_id, out_data);
         end else begin
            logic [ID_W+SIZE-1:0] exp;
            exp = sb.pop_front();
            if ({out_id, out_data} !== exp) begin
               miscompares++;
               $display("FAIL out_result: got id=%0d data=%h, required id=%0d data=%h",
                        out_id, out_data, exp[SIZE+:ID_W], exp[SIZE-1:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic set_lane(input int id, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
      req_a[id*SIZE +: SIZE] = a;
      req_b[id*SIZE +: SIZE] = b;
   endtask

   // Present one request alone, expect an immediate grant, and queue its result.
   task automatic issue_one(input string name, input int id, input logic [SIZE-1:0] a,
                            input logic [SIZE-1:0] b, input logic [SIZE-1:0] exp);
      set_lane(id, a, b);
      req_valid = 4'b0001 << id;
      #1;
      check({name, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
      sb.push_back({ID_W'(id), exp});
      tick();
      req_valid = '0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      check({name, "_drain_left"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      out_ready = 1'b1;
      tick();
      tick();
      // reset state
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_id", 32'(out_id), 32'd0);
      req_valid = '0;
      rst = 1'b0;
      tick();

      // 1: single op from requester 2, with a 2-edge latency
      set_lane(2, 16'h4000, 16'h4000);
      req_valid = 4'b0100;
      #1;
      check("t1_ready", 32'(req_ready), 32'b0100);
      sb.push_back({2'd2, 16'h2000});
      tick();
      req_valid = '0;
      #1;
      check("t1_ready_after", 32'(req_ready), 32'd0);
      check("t1_valid_e1", 32'(out_valid), 32'd0);
      tick();
      check("t1_valid_e2", 32'(out_valid), 32'd1);
      drain("t1");

      // 2: arithmetic corners, back to back on requester 0
      issue_one("t2_neg", 0, 16'hC000, 16'h4000, 16'hE000);
      issue_one("t2_floor", 0, 16'hFFFF, 16'h0001, 16'hFFFF);
      issue_one("t2_wrap", 0, 16'h8000, 16'h8000, 16'h8000);
      issue_one("t2_max", 0, 16'h7FFF, 16'h7FFF, 16'h7FFE);
      drain("t2");

      // Align the pointer to 0 with a grant on requester 3.
      issue_one("t3_align", 3, 16'h4000, 16'h1000 * 4, 16'h0800 * 4);
      drain("t3_align");

      // 3: round-robin with all four requesters valid
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, 16'h4000, 16'(16'h1000 * (i + 1)));
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("t3_rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
         sb.push_back({ID_W'(k % 4), 16'(16'h0800 * ((k % 4) + 1))});
         tick();
      end
      req_valid = '0;
      drain("t3");

      // 4: fairness skip. After grant 1, only requesters 0 and 3 are valid.
      issue_one("t4_g1", 1, 16'h4000, 16'h2000, 16'h1000);
      tick();
      req_valid = 4'b1001;
      #1;
      check("t4_skip_to3", 32'(req_ready), 32'b1000);
      sb.push_back({2'd3, 16'h2000});
      tick();
      check("t4_then0", 32'(req_ready), 32'b0001);
      sb.push_back({2'd0, 16'h0800});
      tick();
      req_valid = '0;
      drain("t4");

      // A requester that drops valid during a stall, without a grant, leaves the pointer alone.
      // The pointer is 1 here. Fill both stages with requester 1 (ptr->2), then requester 2 (ptr->3).
      out_ready = 1'b0;
      issue_one("t4_fill1", 1, 16'h4000, 16'h2000, 16'h1000);
      issue_one("t4_fill2", 2, 16'h4000, 16'h3000, 16'h1800);
      req_valid = 4'b0001;
      #1;
      check("t4_stall_ready", 32'(req_ready), 32'd0);
      tick();
      req_valid = 4'b1001;
      out_ready = 1'b1;
      #1;
      check("t4_ptr_kept", 32'(req_ready), 32'b1000);
      sb.push_back({2'd3, 16'h2000});
      tick();
      req_valid = '0;
      drain("t4b");

      // 5: backpressure. The pointer is 0 here. Stream all four with out_ready low for 5 cycles.
      req_valid = 4'hF;
      out_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k == 5) out_ready = 1'b1;
         #1;
         case (k)
            0: begin check("t5_acc0", 32'(req_ready), 32'b0001); sb.push_back({2'd0, 16'h0800}); end
            1: begin check("t5_acc1", 32'(req_ready), 32'b0010); sb.push_back({2'd1, 16'h1000}); end
            2, 3, 4: begin
               check("t5_stall_ready", 32'(req_ready), 32'd0);
               check("t5_stall_data", 32'(out_data), 32'h0800);
               check("t5_stall_id", 32'(out_id), 32'd0);
            end
            5: begin check("t5_rel2", 32'(req_ready), 32'b0100); sb.push_back({2'd2, 16'h1800}); end
            default: begin check("t5_rel3", 32'(req_ready), 32'b1000); sb.push_back({2'd3, 16'h2000}); end
         endcase
         tick();
      end
      req_valid = '0;
      drain("t5");

      // 6: reset while both stages are full. The pointer is 0 here; two grants move it to 2.
      out_ready = 1'b0;
      req_valid = 4'hF;
      tick();
      tick();
      req_valid = '0;
      #1;
      check("t6_full_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      out_ready = 1'b1;
      req_valid = 4'hF;
      #1;
      check("t6_rst_ready", 32'(req_ready), 32'd0);
      tick();
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_rst_ready2", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("t6_restart0", 32'(req_ready), 32'b0001);
      sb.push_back({2'd0, 16'h0800});
      tick();
      req_valid = '0;
      drain("t6");
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
